irig_symbol_classifier: RTL and testbench

- Front-end of the IRIG-B receive path.
- Samples the asynchronous DC-level-shift IRIG-B input on the system clock and measures each pulse's high width in 0.1 ms ticks.
- Classifies every 10 ms bit cell as ZERO (2 ms), ONE (5 ms), P marker (8 ms) or ERROR, and presents one symbol per cell.
- Directly feeds the reference-marker/sequence detector downstream, which needs a clean per-cell marker flag and strobe.

---
 rtl/irig_pkg.sv | 46 ++++
 rtl/irig_tick_gen.sv | 32 +++
 rtl/irig_symbol_classifier.sv | 135 +++++++++++++
 tb/tb_irig_symbol_classifier.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irig_pkg.sv
// Shared constants, FSM encoding and helpers for the IRIG-B symbol classifier.
package irig_pkg;

    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_P    = 2'b10;
    localparam logic [1:0] SYM_ERR  = 2'b11;

    localparam logic [CNT_W-1:0] TH_GLITCH   = CNT_W'(10);
    localparam logic [CNT_W-1:0] TH_ZERO_MAX = CNT_W'(35);
    localparam logic [CNT_W-1:0] TH_ONE_MAX  = CNT_W'(65);
    localparam logic [CNT_W-1:0] TH_P_MAX    = CNT_W'(95);
    localparam logic [CNT_W-1:0] TH_SHORT    = CNT_W'(90);
    localparam logic [CNT_W-1:0] TH_LOST     = CNT_W'(110);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_t;

    // Saturating tick counter step.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Map a high width in ticks onto a symbol code.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
        logic [1:0] code;
        if (w < TH_GLITCH)
            code = SYM_ERR;
        else if (w < TH_ZERO_MAX)
            code = SYM_ZERO;
        else if (w < TH_ONE_MAX)
            code = SYM_ONE;
        else if (w < TH_P_MAX)
            code = SYM_P;
        else
            code = SYM_ERR;
        return code;
    endfunction

endpackage

// File: rtl/irig_tick_gen.sv
// 0.1 ms tick prescaler; restart realigns the tick phase to a rising edge.
module irig_tick_gen #(
    parameter int unsigned DIV = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + CW'(1);
        if (restart || (cnt == CW'(DIV - 1)))
            cnt_nxt = '0;
    end

    // tick is high exactly while cnt sits at its terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == CW'(DIV - 1)) && !restart;
        end
    end

endmodule

// File: rtl/irig_symbol_classifier.sv
// IRIG-B DCLS front end: synchronizes the input, times each pulse in 0.1 ms
// ticks and emits one ZERO/ONE/P/ERROR symbol per 10 ms bit cell.
module irig_symbol_classifier
    import irig_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irig_in,
    output logic             sym_valid,
    output logic [1:0]       sym_code,
    output logic             sym_marker,
    output logic [CNT_W-1:0] high_width,
    output logic             lost
);
    localparam int unsigned TICK_DIV = CLKS_PER_MS / 10;

    logic             sync1, sync2, sync3;
    logic             rise, fall, tick;
    logic [CNT_W-1:0] w_cnt, p_cnt, w_nxt, p_nxt;
    state_t           state, state_nxt;
    logic             valid_d, marker_d, lost_d;
    logic [1:0]       code_d;
    logic [CNT_W-1:0] width_d;

    // Synchronizer idles high so reset release never fabricates a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= irig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    irig_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .restart(rise),
        .tick   (tick)
    );

    // Counts include the current cycle's tick so a decision sees the full width.
    assign w_nxt = sat_inc(w_cnt, tick);
    assign p_nxt = sat_inc(p_cnt, tick);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_cnt <= '0;
            p_cnt <= '0;
        end else if (rise) begin
            w_cnt <= '0;
            p_cnt <= '0;
        end else begin
            w_cnt <= w_nxt;
            p_cnt <= p_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Edges are tested before timeouts so a coincident edge always wins.
    always_comb begin
        state_nxt = state;
        valid_d   = 1'b0;
        code_d    = sym_code;
        width_d   = high_width;
        lost_d    = lost;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    lost_d    = 1'b0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                    width_d   = w_nxt;
                    code_d    = classify(w_nxt);
                    valid_d   = 1'b1;
                end else if (p_nxt >= TH_LOST) begin
                    state_nxt = ST_IDLE;
                    lost_d    = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    lost_d    = 1'b0;
                    if (p_nxt < TH_SHORT) begin
                        valid_d = 1'b1;
                        code_d  = SYM_ERR;
                    end
                end else if (p_nxt >= TH_LOST) begin
                    state_nxt = ST_IDLE;
                    lost_d    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        marker_d = valid_d && (code_d == SYM_P);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_valid  <= 1'b0;
            sym_code   <= SYM_ZERO;
            sym_marker <= 1'b0;
            high_width <= '0;
            lost       <= 1'b0;
        end else begin
            sym_valid  <= valid_d;
            sym_code   <= code_d;
            sym_marker <= marker_d;
            high_width <= width_d;
            lost       <= lost_d;
        end
    end

endmodule

// File: tb/tb_irig_symbol_classifier.sv
// Bench for irig_symbol_classifier at 100 clocks/ms; expected symbols come from
// pulse timing arithmetic on the driven waveform.
module tb_irig_symbol_classifier;

    localparam int unsigned CPM = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       irig_in;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       sym_marker;
    logic [6:0] high_width;
    logic       lost;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [1:0] code;
        int         w;
        logic       mk;
        bit         chk_w;
    } sym_t;

    sym_t exp_q[$];
    sym_t got_q[$];
    int   hs_q[$];
    int   ps_q[$];

    irig_symbol_classifier #(
        .CLKS_PER_MS(CPM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irig_in   (irig_in),
        .sym_valid (sym_valid),
        .sym_code  (sym_code),
        .sym_marker(sym_marker),
        .high_width(high_width),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sym_t e;
        if (sym_valid === 1'b1) begin
            e.cyc   = cyc;
            e.code  = sym_code;
            e.w     = int'(high_width);
            e.mk    = sym_marker;
            e.chk_w = 1'b1;
            got_q.push_back(e);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] ref_code(input int w);
        if (w < 10) return 2'b11;
        if (w < 35) return 2'b00;
        if (w < 65) return 2'b01;
        if (w < 95) return 2'b10;
        return 2'b11;
    endfunction

    // Drives cells from hs_q/ps_q (clocks) starting in IDLE and records the
    // symbols a correct receiver must produce: one per falling edge (width =
    // whole ticks elapsed), plus ERROR at any rise ending a period under 9 ms.
    task automatic drive_cells();
        int   prev_p;
        sym_t e;
        prev_p = -1;
        for (int i = 0; i < hs_q.size(); i++) begin
            int w;
            irig_in = 1'b1;
            if (prev_p >= 0 && (prev_p / 10) < 90) begin
                e.cyc = cyc + 3; e.code = 2'b11; e.w = 0; e.mk = 1'b0; e.chk_w = 1'b0;
                exp_q.push_back(e);
            end
            repeat (hs_q[i]) @(negedge clk);
            irig_in = 1'b0;
            w = hs_q[i] / 10;
            if (w > 127) w = 127;
            e.cyc = cyc + 3; e.code = ref_code(w); e.w = w; e.mk = (ref_code(w) == 2'b10); e.chk_w = 1'b1;
            exp_q.push_back(e);
            repeat (ps_q[i] - hs_q[i]) @(negedge clk);
            prev_p = ps_q[i];
        end
        hs_q.delete();
        ps_q.delete();
    endtask

    task automatic settle();
        irig_in = 1'b0;
        repeat (1200) @(negedge clk);
    endtask

    task automatic start_scenario();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        irig_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sym_valid !== 1'b0 || sym_code !== 2'b00 || sym_marker !== 1'b0 || high_width !== 7'd0 || lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got valid=%b code=%b marker=%b width=%0d lost=%b, expected all zero",
                     sym_valid, sym_code, sym_marker, high_width, lost);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_release: got %0d symbols, expected 0", got_q.size());
        end
    endtask

    task automatic test_zero_cell();
        start_scenario();
        hs_q.push_back(200); ps_q.push_back(1000);
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL zero_cell count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL zero_cell sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_one_and_markers();
        int marks;
        start_scenario();
        hs_q.push_back(500); ps_q.push_back(1000);
        hs_q.push_back(800); ps_q.push_back(1000);
        hs_q.push_back(800); ps_q.push_back(1000);
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL markers count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL markers sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
        marks = 0;
        foreach (got_q[i]) if (got_q[i].mk === 1'b1) marks++;
        checks++;
        if (marks !== 2) begin
            failures++;
            $display("FAIL marker_pulses: got %0d, expected 2", marks);
        end
    endtask

    task automatic test_boundaries();
        start_scenario();
        hs_q.push_back(90);  ps_q.push_back(1000);
        hs_q.push_back(340); ps_q.push_back(1000);
        hs_q.push_back(350); ps_q.push_back(1000);
        hs_q.push_back(950); ps_q.push_back(1000);
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL boundaries count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL boundaries sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_lost();
        int   r;
        sym_t e;
        start_scenario();
        r = cyc;
        irig_in = 1'b1;
        repeat (200) @(negedge clk);
        irig_in = 1'b0;
        e.cyc = cyc + 3; e.code = 2'b00; e.w = 20; e.mk = 1'b0; e.chk_w = 1'b1;
        exp_q.push_back(e);
        repeat (895) @(negedge clk);
        checks++;
        if (lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_early at %0d clocks: got %b, expected 0", cyc - r, lost);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (lost !== 1'b1) begin
            failures++;
            $display("FAIL lost_set at %0d clocks: got %b, expected 1", cyc - r, lost);
        end
        repeat (90) @(negedge clk);
        hs_q.push_back(200); ps_q.push_back(1000);
        drive_cells();
        checks++;
        if (lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_clear: got %b, expected 0", lost);
        end
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL lost count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL lost sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_short_cell();
        start_scenario();
        hs_q.push_back(200); ps_q.push_back(700);
        hs_q.push_back(200); ps_q.push_back(1000);
        hs_q.push_back(500); ps_q.push_back(1000);
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL short_cell count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL short_cell sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_cell();
        start_scenario();
        irig_in = 1'b1;
        repeat (400) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (sym_valid !== 1'b0 || sym_code !== 2'b00 || sym_marker !== 1'b0 || high_width !== 7'd0 || lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid values: got valid=%b code=%b marker=%b width=%0d lost=%b, expected all zero",
                     sym_valid, sym_code, sym_marker, high_width, lost);
        end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (396) @(negedge clk);
        irig_in = 1'b0;
        repeat (200) @(negedge clk);
        hs_q.push_back(800); ps_q.push_back(1000);
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL reset_mid count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL reset_mid sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        start_scenario();
        for (int i = 0; i < 14; i++) begin
            int h;
            h = int'($urandom_range(1000, 20));
            hs_q.push_back(h);
            ps_q.push_back(h + int'($urandom_range(1090 - h, 30)));
        end
        drive_cells();
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random count: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].code !== exp_q[i].code || got_q[i].cyc !== exp_q[i].cyc || got_q[i].mk !== exp_q[i].mk ||
                (exp_q[i].chk_w && got_q[i].w !== exp_q[i].w)) begin
                failures++;
                $display("FAIL random sym%0d: got code=%b w=%0d mk=%b cyc=%0d, expected code=%b w=%0d mk=%b cyc=%0d",
                         i, got_q[i].code, got_q[i].w, got_q[i].mk, got_q[i].cyc,
                         exp_q[i].code, exp_q[i].w, exp_q[i].mk, exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_cell();
        test_one_and_markers();
        test_boundaries();
        test_lost();
        test_short_cell();
        test_reset_mid_cell();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
